// File: rtl/line_buf_pkg.sv
// Shared definitions for the line-buffer read/write controllers: reader FSM
// states, default bus widths and the FIFO occupancy counter width helper.
package line_buf_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/line_rd_fifo.sv
// Register-based synchronous FIFO holding {last, pixel} entries between the
// RAM read pipeline and the downstream valid/ready interface.
module line_rd_fifo
  import line_buf_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic [fifo_cnt_w(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             full;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign do_pop = pop && !empty;
  // Idle output reads as zero so a flushed FIFO never exposes stale pixels.
  assign rdata  = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The reader's credit scheme must never push into a full FIFO without a pop.
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/line_buf_reader.sv
// Read-side line-buffer controller: walks an address range on the RAM read
// port and returns the pixels as a backpressured stream with end-of-line flag.
module line_buf_reader
  import line_buf_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   line_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic              done_q;
  logic              done_d;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued_q;
  logic [ADDR_W-1:0] addr_q;
  logic              tag_vld_q;
  logic              tag_last_q;

  logic              accept;
  logic              issue;
  logic              issue_last;
  logic              credit;
  logic              pop;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rdata;

  // Credit covers entries already queued plus the read still in the RAM pipe.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, tag_vld_q};
  assign credit    = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

  // State register.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (line_len != '0) state_d = READ;
          else                done_d  = 1'b1;
        end
      end
      READ: begin
        if (issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && fifo_rdata[DATA_W]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    busy       = (state_q != IDLE);
    done       = done_q;
    accept     = (state_q == IDLE) && start && (line_len != '0);
    issue      = (state_q == READ) && credit;
    issue_last = issue && (issued_q == len_q - (ADDR_W + 1)'(1));
    m_valid    = !fifo_empty;
    m_data     = fifo_rdata[DATA_W-1:0];
    m_last     = fifo_rdata[DATA_W];
    pop        = m_valid && m_ready;
    rd_addr    = addr_q;
  end

  // Address walk and issue tagging; the tag lines up with rd_data one edge later.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      len_q      <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      tag_vld_q  <= 1'b0;
      tag_last_q <= 1'b0;
    end else begin
      if (accept) begin
        len_q    <= line_len;
        addr_q   <= base_addr;
        issued_q <= '0;
      end else if (issue) begin
        addr_q   <= addr_q + ADDR_W'(1);
        issued_q <= issued_q + (ADDR_W + 1)'(1);
      end
      tag_vld_q  <= issue;
      tag_last_q <= issue_last;
    end
  end

  line_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (rd_clk),
    .rst   (rd_rst),
    .push  (tag_vld_q),
    .wdata ({tag_last_q, rd_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_line_buf_reader.sv
// Self-checking bench for line_buf_reader: 1-cycle RAM model, expected-pixel
// queue built from base/len arithmetic, and a negedge stream monitor.
module tb_line_buf_reader;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   line_len = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready = 1'b1;

  line_buf_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .rd_clk (clk), .rd_rst (rst), .start (start), .base_addr (base_addr),
    .line_len (line_len), .busy (busy), .done (done), .rd_addr (rd_addr),
    .rd_data (rd_data), .m_data (m_data), .m_valid (m_valid), .m_last (m_last),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [NWORDS];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int ready_pct = 100;

  logic [DATA_W:0] exp_q [$];
  int done_cnt = 0, done_cyc = -1, first_vld = -1, vld_seen = 0;
  int issued_n = 0, accepted_n = 0, max_out = 0;
  logic prev_stall = 1'b0, prev_busy = 1'b0, prev_last = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [ADDR_W-1:0] prev_addr = '0;

  // Stream monitor: scoreboard, stall stability and outstanding-read tracking.
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_valid) begin
        vld_seen++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (prev_stall) begin
        checks++;
        if ({m_valid, m_last, m_data} !== {1'b1, prev_last, prev_data}) begin
          errors++;
          $display("FAIL hold: got v=%0b l=%0b d=%02h want v=1 l=%0b d=%02h",
                   m_valid, m_last, m_data, prev_last, prev_data);
        end
      end
      if (busy && prev_busy && rd_addr != prev_addr) issued_n++;
      if (m_valid && m_ready) begin
        accepted_n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel: unexpected l=%0b d=%02h, nothing expected", m_last, m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            errors++;
            $display("FAIL pixel: got l=%0b d=%02h want l=%0b d=%02h",
                     m_last, m_data, e[DATA_W], e[DATA_W-1:0]);
          end
        end
      end
      if (issued_n - accepted_n > max_out) max_out = issued_n - accepted_n;
      prev_stall = m_valid && !m_ready;
      prev_last  = m_last;
      prev_data  = m_data;
    end
    prev_busy = busy;
    prev_addr = rd_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
    m_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic launch(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    exp_q.delete();
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back({(i == int'(len) - 1), mem[(int'(base) + i) % NWORDS]});
    issued_n = 0; accepted_n = 0; max_out = 0; first_vld = -1; vld_seen = 0;
    base_addr = base;
    line_len  = len;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    expect_int({name, " busy"},    int'(busy),    0);
    expect_int({name, " done"},    int'(done),    0);
    expect_int({name, " m_valid"}, int'(m_valid), 0);
    expect_int({name, " m_last"},  int'(m_last),  0);
    expect_int({name, " m_data"},  int'(m_data),  0);
    expect_int({name, " rd_addr"}, int'(rd_addr), 0);
  endtask

  task automatic test_reset();
    repeat (3) step();
    rst = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_basic();
    int s;
    for (int i = 0; i < NWORDS; i++) mem[i] = 8'(i & 8'hFF);
    ready_pct = 100;
    s = cyc;
    launch(11'd0, 12'd8);
    expect_int("basic busy", int'(busy), 1);
    wait_done("basic", 40);
    expect_int("basic first valid cycle", first_vld - s, 3);
    expect_int("basic done cycle", done_cyc - s, 11);
    expect_int("basic pixels", accepted_n, 8);
    expect_int("basic leftover", exp_q.size(), 0);
    expect_int("basic busy after", int'(busy), 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < NWORDS; i++) mem[i] = 8'($urandom);
    launch(11'd2046, 12'd4);
    wait_done("wrap", 40);
    expect_int("wrap pixels", accepted_n, 4);
    expect_int("wrap leftover", exp_q.size(), 0);
  endtask

  task automatic test_backpressure();
    ready_pct = 50;
    launch(11'($urandom), 12'd16);
    wait_done("backpressure", 400);
    ready_pct = 100;
    expect_int("bp pixels", accepted_n, 16);
    expect_int("bp leftover", exp_q.size(), 0);
    checks++;
    if (max_out > DEPTH) begin
      errors++;
      $display("FAIL bp outstanding: got %0d want <= %0d", max_out, DEPTH);
    end
  endtask

  task automatic test_len0();
    int d0 = done_cnt;
    launch(11'd5, 12'd0);
    expect_int("len0 done next cycle", int'(done), 1);
    expect_int("len0 busy", int'(busy), 0);
    repeat (6) step();
    expect_int("len0 no valid", vld_seen, 0);
    expect_int("len0 single done", done_cnt - d0, 1);
  endtask

  task automatic test_len1();
    launch(11'($urandom), 12'd1);
    wait_done("len1", 20);
    expect_int("len1 pixels", accepted_n, 1);
    expect_int("len1 leftover", exp_q.size(), 0);
  endtask

  task automatic test_len2048();
    ready_pct = 90;
    launch(11'($urandom), 12'd2048);
    wait_done("len2048", 3000);
    ready_pct = 100;
    expect_int("len2048 pixels", accepted_n, 2048);
    expect_int("len2048 leftover", exp_q.size(), 0);
  endtask

  task automatic test_ignored_start();
    int d0 = done_cnt;
    ready_pct = 50;
    launch(11'd100, 12'd6);
    step();
    base_addr = 11'd700;
    line_len  = 12'd9;
    start     = 1'b1;
    step();
    start     = 1'b0;
    wait_done("ignored start", 200);
    ready_pct = 100;
    repeat (15) step();
    expect_int("ignored pixels", accepted_n, 6);
    expect_int("ignored leftover", exp_q.size(), 0);
    expect_int("ignored single done", done_cnt - d0, 1);
    expect_int("ignored idle", int'(busy), 0);
  endtask

  task automatic test_reset_midline();
    int n = 0;
    ready_pct = 100;
    launch(11'($urandom), 12'd20);
    while (accepted_n < 5 && n < 50) begin
      step();
      n++;
    end
    ready_pct = 0;
    repeat (8) step();
    expect_int("mid outstanding at stall", max_out, DEPTH);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("mid reset");
    ready_pct = 100;
    step();
    launch(11'd2040, 12'd10);
    wait_done("post reset line", 40);
    expect_int("post reset pixels", accepted_n, 10);
    expect_int("post reset leftover", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_len1();
    test_len2048();
    test_ignored_start();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
